// File: rtl/md_result_reader.sv
// Host-side unloader for MD_Wrapper results: pulses read_ctrl once per particle,
// captures each d_out word on elem_read and forwards it on a valid/ready stream.
module md_result_reader #(
    parameter int DATA_W   = 192,
    parameter int CNT_W    = 11,
    parameter int READ_GAP = 8,
    parameter int TIMEOUT  = 1023
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  n_particles,
    output logic              read_ctrl,
    input  logic              elem_read,
    input  logic [DATA_W-1:0] d_out,
    output logic [DATA_W-1:0] m_data,
    output logic [CNT_W-1:0]  m_index,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              busy,
    output logic              done,
    output logic              timeout_err
);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam int GAP_W  = (READ_GAP > 1) ? $clog2(READ_GAP) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((READ_GAP > 0) ? READ_GAP - 1 : 0);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_HOLD, S_GAP, S_DONE, S_ERR} state_t;

    state_t            state;
    logic [CNT_W-1:0]  n_lat;
    logic [CNT_W-1:0]  cnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state       <= S_IDLE;
            n_lat       <= '0;
            cnt         <= '0;
            wait_cnt    <= '0;
            gap_cnt     <= '0;
            read_ctrl   <= 1'b0;
            m_data      <= '0;
            m_index     <= '0;
            m_valid     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        n_lat       <= n_particles;
                        cnt         <= '0;
                        wait_cnt    <= '0;
                        timeout_err <= 1'b0;
                        if (n_particles == '0) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state     <= S_REQ;
                            read_ctrl <= 1'b1;
                            busy      <= 1'b1;
                        end
                    end
                end
                S_REQ: begin
                    if (elem_read) begin
                        m_data    <= d_out;
                        m_index   <= cnt;
                        m_valid   <= 1'b1;
                        read_ctrl <= 1'b0;
                        state     <= S_HOLD;
                    end else if (wait_cnt == WAIT_LAST) begin
                        // TIMEOUT cycles of read_ctrl with no answer: give up
                        read_ctrl   <= 1'b0;
                        busy        <= 1'b0;
                        timeout_err <= 1'b1;
                        state       <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        if (cnt == n_lat - CNT_W'(1)) begin
                            state <= S_DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            cnt      <= cnt + CNT_W'(1);
                            wait_cnt <= '0;
                            gap_cnt  <= '0;
                            if (READ_GAP == 0) begin
                                state     <= S_REQ;
                                read_ctrl <= 1'b1;
                            end else begin
                                state <= S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state     <= S_REQ;
                        read_ctrl <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_md_result_reader.sv
// Directed + randomized bench for md_result_reader: an MD_Wrapper responder model
// feeds random words, and the delivered stream is compared with what was sent.
module tb_md_result_reader;
    localparam int DATA_W   = 192;
    localparam int CNT_W    = 11;
    localparam int READ_GAP = 8;
    localparam int TIMEOUT  = 1023;

    logic              ap_clk;
    logic              ap_rst_n;
    logic              start;
    logic [CNT_W-1:0]  n_particles;
    logic              read_ctrl;
    logic              elem_read;
    logic [DATA_W-1:0] d_out;
    logic [DATA_W-1:0] m_data;
    logic [CNT_W-1:0]  m_index;
    logic              m_valid;
    logic              m_ready;
    logic              busy;
    logic              done;
    logic              timeout_err;

    md_result_reader #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .READ_GAP(READ_GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .n_particles(n_particles),
        .read_ctrl(read_ctrl), .elem_read(elem_read), .d_out(d_out),
        .m_data(m_data), .m_index(m_index), .m_valid(m_valid), .m_ready(m_ready),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state: words handed out by the responder, words seen at the sink
    logic [DATA_W-1:0]       sent_q[$];
    logic [CNT_W+DATA_W-1:0] got_q[$];
    int                      gap_q[$];
    int  rise_cnt = 0, done_cnt = 0, low_len = 0, hi_len = 0, last_hi = 0;
    bit  rc_prev  = 1'b0;

    bit  resp_en  = 1'b1;
    bit  stray    = 1'b0;
    int  resp_lat = 4;
    int  rc_cnt   = 0;

    function automatic logic [DATA_W-1:0] rnd_word();
        logic [DATA_W-1:0] w;
        for (int k = 0; k < DATA_W / 32; k++) w[k*32 +: 32] = $urandom;
        return w;
    endfunction

    // MD_Wrapper stand-in: answers resp_lat cycles into each read_ctrl request
    initial begin
        elem_read = 1'b0;
        d_out     = '0;
        forever begin
            @(posedge ap_clk); #2;
            elem_read = 1'b0;
            if (resp_en && read_ctrl) begin
                rc_cnt++;
                if (rc_cnt == resp_lat) begin
                    elem_read = 1'b1;
                    d_out     = rnd_word();
                    sent_q.push_back(d_out);
                end
            end else begin
                rc_cnt = 0;
                if (stray && !read_ctrl) begin
                    elem_read = 1'b1;
                    d_out     = rnd_word();
                end
            end
        end
    end

    // sink and read_ctrl timing monitor, sampling the values of the cycle just ending
    initial forever begin
        @(posedge ap_clk);
        if (m_valid && m_ready) got_q.push_back({m_index, m_data});
        if (done) done_cnt++;
        if (read_ctrl && !rc_prev) begin
            rise_cnt++;
            gap_q.push_back(low_len);
            hi_len = 0;
        end
        if (!read_ctrl && rc_prev) last_hi = hi_len;
        if (read_ctrl) begin
            hi_len++;
            low_len = 0;
        end else begin
            low_len++;
        end
        rc_prev = read_ctrl;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk); #1;
    endtask

    task automatic do_start(input int n);
        start       = 1'b1;
        n_particles = CNT_W'(n);
        tick();
        start       = 1'b0;
        n_particles = CNT_W'($urandom);
    endtask

    task automatic wait_done(input int budget, input bit rnd_ready, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
            tick();
            if (done) ok = 1'b1;
        end
    endtask

    task automatic wait_valid(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget && !ok; c++) begin
            if (m_valid) ok = 1'b1;
            else tick();
        end
    endtask

    task automatic check_stream(input string tag, input int n);
        logic [CNT_W-1:0] idx;
        chk({tag, "_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            idx = i[CNT_W-1:0];
            chk({tag, "_word"}, got_q[i], {idx, sent_q[i]});
        end
    endtask

    task automatic clear_model();
        sent_q.delete();
        got_q.delete();
        gap_q.delete();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_read_ctrl"}, read_ctrl, 0);
        chk({tag, "_m_valid"}, m_valid, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_m_index"}, m_index, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    initial begin
        bit ok;
        int r0, d0, n;
        logic [DATA_W-1:0] held;

        ap_rst_n    = 1'b0;
        start       = 1'b0;
        n_particles = '0;
        m_ready     = 1'b1;
        repeat (3) tick();
        chk_all_zero("reset");
        ap_rst_n = 1'b1;
        tick();

        // three particles, fixed response latency, sink always ready
        clear_model();
        r0 = rise_cnt; d0 = done_cnt;
        resp_lat = 4;
        do_start(3);
        chk("t1_busy", busy, 1);
        wait_done(500, 1'b0, ok);
        chk("t1_done_seen", ok, 1);
        chk("t1_busy_at_done", busy, 0);
        tick(); tick();
        chk("t1_done_pulses", done_cnt - d0, 1);
        chk("t1_rc_pulses", rise_cnt - r0, 3);
        chk("t1_rc_idle", read_ctrl, 0);
        chk("t1_busy_after", busy, 0);
        check_stream("t1", 3);
        // read_ctrl low between requests: handshake cycle plus READ_GAP
        chk("t3_gap_count", gap_q.size(), 3);
        chk("t3_gap1", gap_q[1], READ_GAP + 1);
        chk("t3_gap2", gap_q[2], READ_GAP + 1);

        // sink stalls on index 1; stray elem_read pulses must not disturb the held word
        clear_model();
        resp_lat = 3;
        m_ready  = 1'b0;
        do_start(3);
        wait_valid(200, ok);
        chk("t2_valid0", ok, 1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        wait_valid(200, ok);
        chk("t2_valid1", ok, 1);
        chk("t2_idx1", m_index, 1);
        held  = m_data;
        stray = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("t2_hold_valid", m_valid, 1);
            chk("t2_hold_data", m_data, held);
            chk("t2_hold_idx", m_index, 1);
            chk("t2_hold_rc", read_ctrl, 0);
        end
        stray   = 1'b0;
        m_ready = 1'b1;
        wait_done(300, 1'b0, ok);
        chk("t2_done_seen", ok, 1);
        tick();
        check_stream("t2", 3);

        // no responder: timeout after TIMEOUT request cycles, flag sticky until next start
        clear_model();
        resp_en = 1'b0;
        r0 = rise_cnt; d0 = done_cnt;
        do_start(2);
        chk("t4_busy", busy, 1);
        ok = 1'b0;
        for (int c = 0; c < TIMEOUT + 100 && !ok; c++) begin
            tick();
            if (!busy) ok = 1'b1;
        end
        chk("t4_busy_fell", ok, 1);
        chk("t4_err", timeout_err, 1);
        chk("t4_rc_low", read_ctrl, 0);
        tick(); tick(); tick();
        chk("t4_err_sticky", timeout_err, 1);
        chk("t4_req_len", last_hi, TIMEOUT);
        chk("t4_rc_pulses", rise_cnt - r0, 1);
        chk("t4_no_done", done_cnt - d0, 0);
        resp_en = 1'b1;
        clear_model();
        do_start(1);
        chk("t4_err_cleared", timeout_err, 0);
        wait_done(200, 1'b0, ok);
        chk("t4_recover_done", ok, 1);
        tick();
        check_stream("t4", 1);

        // zero particles: immediate done, no request
        r0 = rise_cnt; d0 = done_cnt;
        do_start(0);
        chk("t5_done", done, 1);
        chk("t5_rc", read_ctrl, 0);
        chk("t5_busy", busy, 0);
        tick();
        chk("t5_done_fell", done, 0);
        tick(); tick(); tick();
        chk("t5_no_rc", rise_cnt - r0, 0);
        chk("t5_one_done", done_cnt - d0, 1);

        // reset while index 150 of 300 is being held
        clear_model();
        resp_lat = 2;
        do_start(300);
        ok = 1'b0;
        for (int c = 0; c < 8000 && !ok; c++) begin
            tick();
            if (m_valid && m_index == CNT_W'(150)) ok = 1'b1;
        end
        chk("t6_reached150", ok, 1);
        ap_rst_n = 1'b0;
        m_ready  = 1'b0;
        tick();
        chk_all_zero("t6_reset");
        ap_rst_n = 1'b1;
        m_ready  = 1'b1;
        tick(); tick();
        chk("t6_idle_rc", read_ctrl, 0);
        chk("t6_idle_busy", busy, 0);
        check_stream("t6_pre", 150);
        clear_model();
        do_start(2);
        wait_done(200, 1'b0, ok);
        chk("t6_restart_done", ok, 1);
        tick();
        check_stream("t6_restart", 2);

        // random lengths, latencies and sink back-pressure; start while busy is ignored
        for (int it = 0; it < 3; it++) begin
            clear_model();
            n        = $urandom_range(5, 12);
            resp_lat = $urandom_range(1, 6);
            d0       = done_cnt;
            do_start(n);
            start       = 1'b1;
            n_particles = '0;
            tick();
            start = 1'b0;
            wait_done(3000, 1'b1, ok);
            m_ready = 1'b1;
            chk("t7_done_seen", ok, 1);
            tick(); tick();
            chk("t7_one_done", done_cnt - d0, 1);
            check_stream("t7", n);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
